// File: rtl/rxn_round_engine_if.sv
// rxn_round_engine_if
//   Groups the player-facing signals of one reaction-round engine.
//   master : upstream key logic / display side (drives start, stop; reads results)
//   slave  : the engine itself
//   Signals:
//     start, stop   single-cycle pulses from the debounced keys
//     stim          stimulus LED, high while the player should react
//     busy          session running
//     rxn_bcd       last reaction time in BCD, digit 0 = ms ones
//     rxn_valid     one-cycle pulse when rxn_bcd updates
//     false_start   sticky, stop pressed during the pre-stimulus delay
//     timeout       sticky, counter saturated at all-9s
//     round_idx     current / last round number, 1-based
//     session_done  one-cycle pulse when the final round completes
//     state_dbg     engine FSM state, for observation only
//     best_bcd      best time of the session (only with RXN_BEST_TIME_EN)
//   Valid/ready note: this block has no back-pressure. Every output event
//   (rxn_valid, session_done) is a single-cycle pulse that the consumer must
//   sample in that cycle; start/stop are accepted only in the states that use
//   them and are silently dropped otherwise.
interface rxn_round_engine_if #(
    parameter int DIGITS = 4
);
    logic                start;
    logic                stop;
    logic                stim;
    logic                busy;
    logic [4*DIGITS-1:0] rxn_bcd;
    logic                rxn_valid;
    logic                false_start;
    logic                timeout;
    logic [3:0]          round_idx;
    logic                session_done;
    logic [2:0]          state_dbg;
`ifdef RXN_BEST_TIME_EN
    logic [4*DIGITS-1:0] best_bcd;

    modport master (
        output start, stop,
        input  stim, busy, rxn_bcd, rxn_valid, false_start, timeout,
        input  round_idx, session_done, state_dbg, best_bcd
    );
    modport slave (
        input  start, stop,
        output stim, busy, rxn_bcd, rxn_valid, false_start, timeout,
        output round_idx, session_done, state_dbg, best_bcd
    );
`else
    modport master (
        output start, stop,
        input  stim, busy, rxn_bcd, rxn_valid, false_start, timeout,
        input  round_idx, session_done, state_dbg
    );
    modport slave (
        input  start, stop,
        output stim, busy, rxn_bcd, rxn_valid, false_start, timeout,
        output round_idx, session_done, state_dbg
    );
`endif
endinterface

// File: rtl/rxn_round_engine.sv
// rxn_round_engine
//   Runs a session of NUM_ROUNDS reaction rounds from a single start pulse.
//   Each round waits MIN_DELAY_MS plus a pseudo-random 0..2^RAND_BITS-1 ms,
//   raises stim, and counts the reaction time directly in BCD at 1 ms
//   resolution. Stop during the delay is a false start; reaching all-9s
//   before stop is a timeout. Either aborts the session.
//   Ports:
//     clk  system clock
//     rst  synchronous active-high reset
//     bus  rxn_round_engine_if.slave (start/stop in; stim, busy, results out)
//   Optional feature: define RXN_BEST_TIME_EN to build the best-time register
//   (bus.best_bcd) and its digit-wise BCD compare.
module rxn_round_engine #(
    parameter int TICKS_PER_MS = 50000,
    parameter int DIGITS       = 4,
    parameter int NUM_ROUNDS   = 3,
    parameter int MIN_DELAY_MS = 1000,
    parameter int RAND_BITS    = 11,
    parameter int GAP_MS       = 500
) (
    input logic              clk,
    input logic              rst,
    rxn_round_engine_if.slave bus
);

    localparam int PW      = (TICKS_PER_MS > 1) ? $clog2(TICKS_PER_MS) : 1;
    localparam int DLY_MAX = MIN_DELAY_MS + (1 << RAND_BITS) - 1;
    localparam int CNT_MAX = (DLY_MAX > GAP_MS) ? DLY_MAX : GAP_MS;
    localparam int DW      = (CNT_MAX > 1) ? $clog2(CNT_MAX + 1) : 1;
    localparam int BW      = 4 * DIGITS;

    localparam logic [BW-1:0] ALL9       = {DIGITS{4'h9}};
    localparam logic [PW-1:0] PRESC_LAST = PW'(TICKS_PER_MS - 1);
    localparam logic [3:0]    LAST_ROUND = 4'(NUM_ROUNDS);
    localparam logic [15:0]   LFSR_SEED  = 16'hACE1;

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_DELAY = 3'd1,
        S_ARMED = 3'd2,
        S_GAP   = 3'd3,
        S_FAULT = 3'd4
    } state_t;

    state_t          state_q, state_d;
    logic [PW-1:0]   presc_q, presc_d;
    logic [DW-1:0]   delay_q, delay_d;      // ms countdown, shared by DELAY and GAP
    logic [BW-1:0]   cnt_q, cnt_d;          // live BCD reaction counter
    logic [BW-1:0]   rxn_bcd_q, rxn_bcd_d;
    logic            rxn_valid_q, rxn_valid_d;
    logic            stim_q, stim_d;
    logic            busy_q, busy_d;
    logic            false_start_q, false_start_d;
    logic            timeout_q, timeout_d;
    logic [3:0]      round_q, round_d;
    logic            done_q, done_d;
    logic [15:0]     lfsr_q, lfsr_d;
`ifdef RXN_BEST_TIME_EN
    logic [BW-1:0]   best_q, best_d;
`endif

    logic            tick;
    logic            lfsr_fb;
    logic [DW-1:0]   rand_delay;
    logic [BW-1:0]   cnt_inc;
    logic [BW-1:0]   cap;

    // Decimal increment with ripple carry: a 9 wraps to 0 and passes the carry on.
    function automatic logic [BW-1:0] bcd_inc(input logic [BW-1:0] v);
        logic [BW-1:0] r;
        logic          c;
        r = v;
        c = 1'b1;
        for (int i = 0; i < DIGITS; i++) begin
            if (c) begin
                if (v[4*i +: 4] == 4'd9) begin
                    r[4*i +: 4] = 4'd0;
                end else begin
                    r[4*i +: 4] = v[4*i +: 4] + 4'd1;
                    c = 1'b0;
                end
            end
        end
        return r;
    endfunction

`ifdef RXN_BEST_TIME_EN
    // a < b, decided by the most significant digit that differs.
    function automatic logic bcd_less(input logic [BW-1:0] a, input logic [BW-1:0] b);
        logic lt;
        logic decided;
        lt      = 1'b0;
        decided = 1'b0;
        for (int i = DIGITS - 1; i >= 0; i--) begin
            if (!decided && (a[4*i +: 4] != b[4*i +: 4])) begin
                lt      = (a[4*i +: 4] < b[4*i +: 4]);
                decided = 1'b1;
            end
        end
        return lt;
    endfunction
`endif

    assign tick       = (state_q != S_IDLE) && (presc_q == PRESC_LAST);
    assign lfsr_fb    = lfsr_q[15] ^ lfsr_q[13] ^ lfsr_q[12] ^ lfsr_q[10];
    assign rand_delay = DW'(MIN_DELAY_MS) + DW'(lfsr_q[RAND_BITS-1:0]);
    assign cnt_inc    = bcd_inc(cnt_q);

    always_comb begin
        state_d       = state_q;
        delay_d       = delay_q;
        cnt_d         = cnt_q;
        rxn_bcd_d     = rxn_bcd_q;
        rxn_valid_d   = 1'b0;
        stim_d        = stim_q;
        busy_d        = busy_q;
        false_start_d = false_start_q;
        timeout_d     = timeout_q;
        round_d       = round_q;
        done_d        = 1'b0;
        lfsr_d        = {lfsr_q[14:0], lfsr_fb};
        cap           = tick ? cnt_inc : cnt_q;  // a stop on a tick cycle includes that tick
`ifdef RXN_BEST_TIME_EN
        best_d        = best_q;
`endif

        case (state_q)
            S_IDLE, S_FAULT: begin
                if (bus.start) begin
                    state_d       = S_DELAY;
                    round_d       = 4'd1;
                    false_start_d = 1'b0;
                    timeout_d     = 1'b0;
                    busy_d        = 1'b1;
                    delay_d       = rand_delay;
`ifdef RXN_BEST_TIME_EN
                    best_d        = ALL9;
`endif
                end
            end

            S_DELAY: begin
                if (bus.stop) begin
                    false_start_d = 1'b1;
                    busy_d        = 1'b0;
                    state_d       = S_FAULT;
                end else if (tick) begin
                    if (delay_q <= DW'(1)) begin
                        stim_d  = 1'b1;
                        cnt_d   = '0;
                        state_d = S_ARMED;
                    end else begin
                        delay_d = delay_q - DW'(1);
                    end
                end
            end

            S_ARMED: begin
                // Stop is checked first so it wins over a coincident saturating tick.
                if (bus.stop) begin
                    rxn_bcd_d   = cap;
                    rxn_valid_d = 1'b1;
                    stim_d      = 1'b0;
                    delay_d     = DW'(GAP_MS);
                    state_d     = S_GAP;
`ifdef RXN_BEST_TIME_EN
                    if (bcd_less(cap, best_q)) begin
                        best_d = cap;
                    end
`endif
                end else if (tick) begin
                    cnt_d = cnt_inc;
                    if (cnt_inc == ALL9) begin
                        timeout_d   = 1'b1;
                        rxn_bcd_d   = ALL9;
                        rxn_valid_d = 1'b1;
                        stim_d      = 1'b0;
                        busy_d      = 1'b0;
                        state_d     = S_FAULT;
                    end
                end
            end

            S_GAP: begin
                if (tick) begin
                    if (delay_q <= DW'(1)) begin
                        if (round_q == LAST_ROUND) begin
                            done_d  = 1'b1;
                            busy_d  = 1'b0;
                            state_d = S_IDLE;
                        end else begin
                            round_d = round_q + 4'd1;
                            delay_d = rand_delay;
                            state_d = S_DELAY;
                        end
                    end else begin
                        delay_d = delay_q - DW'(1);
                    end
                end
            end

            default: begin
                state_d = S_IDLE;
            end
        endcase

        // The ms prescaler restarts on every state entry so each phase gets full ms.
        presc_d = presc_q + PW'(1);
        if ((state_d != state_q) || (state_q == S_IDLE) || tick) begin
            presc_d = '0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q       <= S_IDLE;
            presc_q       <= '0;
            delay_q       <= '0;
            cnt_q         <= '0;
            rxn_bcd_q     <= '0;
            rxn_valid_q   <= 1'b0;
            stim_q        <= 1'b0;
            busy_q        <= 1'b0;
            false_start_q <= 1'b0;
            timeout_q     <= 1'b0;
            round_q       <= 4'd0;
            done_q        <= 1'b0;
            lfsr_q        <= LFSR_SEED;
`ifdef RXN_BEST_TIME_EN
            best_q        <= ALL9;
`endif
        end else begin
            state_q       <= state_d;
            presc_q       <= presc_d;
            delay_q       <= delay_d;
            cnt_q         <= cnt_d;
            rxn_bcd_q     <= rxn_bcd_d;
            rxn_valid_q   <= rxn_valid_d;
            stim_q        <= stim_d;
            busy_q        <= busy_d;
            false_start_q <= false_start_d;
            timeout_q     <= timeout_d;
            round_q       <= round_d;
            done_q        <= done_d;
            lfsr_q        <= lfsr_d;
`ifdef RXN_BEST_TIME_EN
            best_q        <= best_d;
`endif
        end
    end

    assign bus.stim         = stim_q;
    assign bus.busy         = busy_q;
    assign bus.rxn_bcd      = rxn_bcd_q;
    assign bus.rxn_valid    = rxn_valid_q;
    assign bus.false_start  = false_start_q;
    assign bus.timeout      = timeout_q;
    assign bus.round_idx    = round_q;
    assign bus.session_done = done_q;
    assign bus.state_dbg    = state_q;
`ifdef RXN_BEST_TIME_EN
    assign bus.best_bcd     = best_q;
`endif

endmodule

// File: tb/tb_rxn_round_engine.sv
// tb_rxn_round_engine
//   Two engines share clk/rst: dut_a (4 digits, 3 rounds) and dut_b
//   (2 digits, 1 round), both with 4 clk per ms, 10..13 ms delay, 2 ms gap.
//   Expected results are pushed into per-engine queues by the stimulus;
//   a negedge monitor pops and compares on every rxn_valid / session_done.
module tb_rxn_round_engine;

    logic clk;
    logic rst;

    rxn_round_engine_if #(.DIGITS(4)) bus_a ();
    rxn_round_engine_if #(.DIGITS(2)) bus_b ();

    rxn_round_engine #(
        .TICKS_PER_MS(4), .DIGITS(4), .NUM_ROUNDS(3),
        .MIN_DELAY_MS(10), .RAND_BITS(2), .GAP_MS(2)
    ) dut_a (
        .clk (clk),
        .rst (rst),
        .bus (bus_a.slave)
    );

    rxn_round_engine #(
        .TICKS_PER_MS(4), .DIGITS(2), .NUM_ROUNDS(1),
        .MIN_DELAY_MS(10), .RAND_BITS(2), .GAP_MS(2)
    ) dut_b (
        .clk (clk),
        .rst (rst),
        .bus (bus_b.slave)
    );

    // ---------------- clock ----------------
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ---------------- scoreboard ----------------
    int errors = 0;
    int checks = 0;

    logic [16:0] exp_a_q[$];     // {timeout, rxn_bcd}
    logic [16:0] exp_b_q[$];
    logic [3:0]  done_a_q[$];    // expected round_idx at session_done
    logic [3:0]  done_b_q[$];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic unexpected(input string name, input logic [31:0] act);
        checks++;
        errors++;
        $display("FAIL %s: unexpected event, value %h at %0t", name, act, $time);
    endtask

    logic        a_valid_prev = 1'b0;
    logic        b_valid_prev = 1'b0;
    logic [16:0] ea;
    logic [16:0] eb;
    logic [3:0]  ed;

    always @(negedge clk) begin
        if (bus_a.rxn_valid) begin
            check("a_valid_width", 32'(a_valid_prev), 32'd0);
            if (exp_a_q.size() == 0) begin
                unexpected("a_rxn_valid", 32'(bus_a.rxn_bcd));
            end else begin
                ea = exp_a_q.pop_front();
                check("a_rxn_bcd", 32'(bus_a.rxn_bcd), 32'(ea[15:0]));
                check("a_rxn_timeout", 32'(bus_a.timeout), 32'(ea[16]));
                check("a_rxn_stim_low", 32'(bus_a.stim), 32'd0);
            end
        end
        if (bus_b.rxn_valid) begin
            check("b_valid_width", 32'(b_valid_prev), 32'd0);
            if (exp_b_q.size() == 0) begin
                unexpected("b_rxn_valid", 32'(bus_b.rxn_bcd));
            end else begin
                eb = exp_b_q.pop_front();
                check("b_rxn_bcd", 32'(bus_b.rxn_bcd), 32'(eb[7:0]));
                check("b_rxn_timeout", 32'(bus_b.timeout), 32'(eb[16]));
                check("b_rxn_stim_low", 32'(bus_b.stim), 32'd0);
            end
        end
        if (bus_a.session_done) begin
            if (done_a_q.size() == 0) begin
                unexpected("a_session_done", 32'(bus_a.round_idx));
            end else begin
                ed = done_a_q.pop_front();
                check("a_done_round", 32'(bus_a.round_idx), 32'(ed));
                check("a_done_busy", 32'(bus_a.busy), 32'd0);
            end
        end
        if (bus_b.session_done) begin
            if (done_b_q.size() == 0) begin
                unexpected("b_session_done", 32'(bus_b.round_idx));
            end else begin
                ed = done_b_q.pop_front();
                check("b_done_round", 32'(bus_b.round_idx), 32'(ed));
                check("b_done_busy", 32'(bus_b.busy), 32'd0);
            end
        end
        a_valid_prev = bus_a.rxn_valid;
        b_valid_prev = bus_b.rxn_valid;
    end

    // ---------------- driver tasks ----------------
    // Inputs change 1 time unit after a rising edge and are sampled on the next one.
    task automatic pulse_start(input bit b);
        @(posedge clk);
        #1;
        if (b) bus_b.start = 1'b1;
        else   bus_a.start = 1'b1;
        @(posedge clk);
        #1;
        bus_a.start = 1'b0;
        bus_b.start = 1'b0;
    endtask

    // Called at the negedge where stim was first seen (cycle 0): stop is
    // applied in cycle n, so the captured time is floor((n+1)/4) ms.
    task automatic pulse_stop(input bit b, input int n);
        repeat (n) @(posedge clk);
        #1;
        if (b) bus_b.stop = 1'b1;
        else   bus_a.stop = 1'b1;
        @(posedge clk);
        #1;
        bus_a.stop = 1'b0;
        bus_b.stop = 1'b0;
        @(negedge clk);
        if (b) check("b_valid_latency", 32'(bus_b.rxn_valid), 32'd1);
        else   check("a_valid_latency", 32'(bus_a.rxn_valid), 32'd1);
    endtask

    // which: 0 a.stim, 1 b.stim, 2 a.rxn_valid, 3 b.rxn_valid, 4 a.done, 5 b.done
    task automatic wait_evt(input int which, input int limit, input string name, output int n);
        logic seen;
        n    = 0;
        seen = 1'b0;
        while (!seen && n < limit) begin
            @(negedge clk);
            n++;
            case (which)
                0: seen = bus_a.stim;
                1: seen = bus_b.stim;
                2: seen = bus_a.rxn_valid;
                3: seen = bus_b.rxn_valid;
                4: seen = bus_a.session_done;
                default: seen = bus_b.session_done;
            endcase
        end
        check(name, 32'(seen), 32'd1);
    endtask

    // After pulse_start a delay of D ms puts stim on negedge 4*D+1, D in 10..13.
    task automatic check_first_delay(input string name, input int n);
        check(name, 32'((n % 4 == 1) && (n >= 41) && (n <= 53)), 32'd1);
    endtask

    // ---------------- stimulus ----------------
    int n;
    int stim_hi;

    initial begin
        rst         = 1'b1;
        bus_a.start = 1'b0;
        bus_a.stop  = 1'b0;
        bus_b.start = 1'b0;
        bus_b.stop  = 1'b0;

        // Reset state
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("rst_a_stim", 32'(bus_a.stim), 32'd0);
        check("rst_a_busy", 32'(bus_a.busy), 32'd0);
        check("rst_a_bcd", 32'(bus_a.rxn_bcd), 32'd0);
        check("rst_a_round", 32'(bus_a.round_idx), 32'd0);
        check("rst_a_flags", 32'({bus_a.false_start, bus_a.timeout, bus_a.rxn_valid, bus_a.session_done}), 32'd0);
        check("rst_b_busy", 32'(bus_b.busy), 32'd0);
        check("rst_b_bcd", 32'(bus_b.rxn_bcd), 32'd0);
`ifdef RXN_BEST_TIME_EN
        check("rst_a_best", 32'(bus_a.best_bcd), 32'h9999);
`endif
        @(posedge clk);
        #1;
        rst = 1'b0;

        // 1) single round on dut_b, stop 37 ms after stim
        pulse_start(1'b1);
        check("b1_busy", 32'(bus_b.busy), 32'd1);
        check("b1_round", 32'(bus_b.round_idx), 32'd1);
        wait_evt(1, 80, "b1_stim_rise", n);
        check_first_delay("b1_delay", n);
        exp_b_q.push_back({1'b0, 16'h0037});
        done_b_q.push_back(4'd1);
        pulse_stop(1'b1, 37 * 4);
        check("b1_gap_busy", 32'(bus_b.busy), 32'd1);
        wait_evt(5, 40, "b1_done_seen", n);
        check("b1_done_delay", 32'(n), 32'd8);
        check("b1_idle_stim", 32'(bus_b.stim), 32'd0);

        // 2) no stop on dut_b: saturate at 0x99
        pulse_start(1'b1);
        wait_evt(1, 80, "b2_stim_rise", n);
        exp_b_q.push_back({1'b1, 16'h0099});
        wait_evt(3, 500, "b2_timeout_seen", n);
        check("b2_timeout_cycles", 32'(n), 32'd396);
        repeat (20) @(negedge clk);
        check("b2_timeout_sticky", 32'(bus_b.timeout), 32'd1);
        check("b2_fault_busy", 32'(bus_b.busy), 32'd0);
        check("b2_fault_stim", 32'(bus_b.stim), 32'd0);

        // 3) start from FAULT, stop on the saturating tick: stop wins
        pulse_start(1'b1);
        check("b3_timeout_clr", 32'(bus_b.timeout), 32'd0);
        check("b3_busy", 32'(bus_b.busy), 32'd1);
        wait_evt(1, 80, "b3_stim_rise", n);
        check_first_delay("b3_delay", n);
        exp_b_q.push_back({1'b0, 16'h0099});
        done_b_q.push_back(4'd1);
        pulse_stop(1'b1, 395);
        check("b3_no_timeout", 32'(bus_b.timeout), 32'd0);
        check("b3_gap_busy", 32'(bus_b.busy), 32'd1);
        wait_evt(5, 40, "b3_done_seen", n);
        check("b3_done_delay", 32'(n), 32'd8);

        // 4) false start on dut_a 5 ms into the delay
        pulse_start(1'b0);
        repeat (20) @(posedge clk);
        #1;
        bus_a.stop = 1'b1;
        @(posedge clk);
        #1;
        bus_a.stop = 1'b0;
        @(negedge clk);
        check("a4_false_start", 32'(bus_a.false_start), 32'd1);
        check("a4_busy", 32'(bus_a.busy), 32'd0);
        stim_hi = 0;
        for (int i = 0; i < 80; i++) begin
            @(negedge clk);
            if (bus_a.stim) stim_hi++;
        end
        check("a4_stim_never", 32'(stim_hi), 32'd0);
        check("a4_fs_sticky", 32'(bus_a.false_start), 32'd1);

        // 5) three rounds on dut_a: 120 / 80 / 95 ms, start while busy ignored
        pulse_start(1'b0);
        check("a5_fs_clr", 32'(bus_a.false_start), 32'd0);
        check("a5_busy", 32'(bus_a.busy), 32'd1);
        wait_evt(0, 80, "a5_r1_stim", n);
        check_first_delay("a5_r1_delay", n);
        check("a5_r1_round", 32'(bus_a.round_idx), 32'd1);
        exp_a_q.push_back({1'b0, 16'h0120});
        pulse_stop(1'b0, 120 * 4);
        pulse_start(1'b0);
        check("a5_ignored_round", 32'(bus_a.round_idx), 32'd1);
        check("a5_ignored_busy", 32'(bus_a.busy), 32'd1);
        wait_evt(0, 100, "a5_r2_stim", n);
        check("a5_r2_round", 32'(bus_a.round_idx), 32'd2);
        exp_a_q.push_back({1'b0, 16'h0080});
        pulse_stop(1'b0, 80 * 4);
        wait_evt(0, 100, "a5_r3_stim", n);
        check("a5_r3_round", 32'(bus_a.round_idx), 32'd3);
        exp_a_q.push_back({1'b0, 16'h0095});
        done_a_q.push_back(4'd3);
        pulse_stop(1'b0, 95 * 4);
        wait_evt(4, 40, "a5_done_seen", n);
        check("a5_done_delay", 32'(n), 32'd8);
        check("a5_last_bcd", 32'(bus_a.rxn_bcd), 32'h0095);
`ifdef RXN_BEST_TIME_EN
        check("a5_best", 32'(bus_a.best_bcd), 32'h0080);
`endif

        // 6) reset in the middle of ARMED
        pulse_start(1'b0);
        wait_evt(0, 80, "a6_stim_rise", n);
        repeat (30) @(posedge clk);
        #1;
        rst = 1'b1;
        @(posedge clk);
        #1;
        check("a6_rst_stim", 32'(bus_a.stim), 32'd0);
        check("a6_rst_busy", 32'(bus_a.busy), 32'd0);
        check("a6_rst_bcd", 32'(bus_a.rxn_bcd), 32'd0);
        check("a6_rst_round", 32'(bus_a.round_idx), 32'd0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        repeat (20) @(negedge clk);
        check("a6_idle_busy", 32'(bus_a.busy), 32'd0);

        // every pushed expectation must have been consumed
        check("a_rxn_queue_empty", 32'(exp_a_q.size()), 32'd0);
        check("b_rxn_queue_empty", 32'(exp_b_q.size()), 32'd0);
        check("a_done_queue_empty", 32'(done_a_q.size()), 32'd0);
        check("b_done_queue_empty", 32'(done_b_q.size()), 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
